// File: rtl/gate_response_checker.sv
// Gate-exercise sink: checks each accepted (vec_in, dut_out) sample against a latched reference function.
// Optional GATE_CHK_MISR_EN adds a 16-bit response signature port misr_sig.
module gate_response_checker #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       func_sel,
  input  logic             vec_valid,
  input  logic [N_IN-1:0]  vec_in,
  input  logic             dut_out,
  output logic             vec_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_vld,
  output logic [N_IN-1:0]  first_err_vec
`ifdef GATE_CHK_MISR_EN
  ,
  output logic [15:0]      misr_sig
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << N_IN) - 1);

  state_e            state_q, state_d;
  logic [2:0]        func_q, func_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              ferr_vld_q, ferr_vld_d;
  logic [N_IN-1:0]   ferr_vec_q, ferr_vec_d;
`ifdef GATE_CHK_MISR_EN
  logic [15:0]       misr_q, misr_d;
  logic              misr_fb;
`endif

  logic accept;
  logic start_run;
  logic expected;

  assign accept    = vec_valid && (state_q == ST_RUN);
  assign start_run = start && (state_q != ST_RUN);

  always_comb begin
    expected = 1'b0;
    unique casez (func_q)
      3'b000:  expected = &vec_in;
      3'b001:  expected = |vec_in;
      3'b010:  expected = ~&vec_in;
      3'b011:  expected = ~|vec_in;
      3'b100:  expected = ^vec_in;
      3'b101:  expected = ~^vec_in;
      default: expected = ~&vec_in;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    ferr_vld_d = ferr_vld_q;
    ferr_vec_d = ferr_vec_q;
`ifdef GATE_CHK_MISR_EN
    misr_d     = misr_q;
    misr_fb    = misr_q[15] ^ dut_out;
`endif
    if (start_run) begin
      state_d    = ST_RUN;
      func_d     = func_sel;
      vec_cnt_d  = '0;
      err_cnt_d  = '0;
      ferr_vld_d = 1'b0;
      ferr_vec_d = '0;
`ifdef GATE_CHK_MISR_EN
      misr_d     = '1;
`endif
    end else if (accept) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
      if (dut_out != expected) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (!ferr_vld_q) begin
          ferr_vld_d = 1'b1;
          ferr_vec_d = vec_in;
        end
      end
`ifdef GATE_CHK_MISR_EN
      misr_d = {misr_q[14:0], 1'b0} ^ (misr_fb ? 16'h1021 : 16'h0000);
`endif
      // Final accept leaves RUN on the same edge so no extra sample is taken.
      if (vec_cnt_q == LAST_CNT) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      func_q     <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      ferr_vld_q <= 1'b0;
      ferr_vec_q <= '0;
`ifdef GATE_CHK_MISR_EN
      misr_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      ferr_vld_q <= ferr_vld_d;
      ferr_vec_q <= ferr_vec_d;
`ifdef GATE_CHK_MISR_EN
      misr_q     <= misr_d;
`endif
    end
  end

  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign vec_ready     = busy;
  assign pass          = done && (err_cnt_q == '0);
  assign vec_cnt       = vec_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_vld = ferr_vld_q;
  assign first_err_vec = ferr_vec_q;
`ifdef GATE_CHK_MISR_EN
  assign misr_sig      = misr_q;
`endif

endmodule
